walk_button_conditioner: RTL and testbench

Conditions the raw, asynchronous pedestrian walk push-button into a single clean request pulse for the walk register's set input. It synchronises the button, debounces press and release against a slow tick from the clock divider, and emits exactly one `WS_Sync` pulse per qualified press. It sits directly upstream of the walk register; the controller FSM can mask requests during the walk phase.

---
 rtl/walk_button_conditioner.sv | 95 +++++++++
 tb/tb_walk_button_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/walk_button_conditioner.sv
// walk_button_conditioner: sync + debounce walk button into a one-cycle request pulse; WS_LOCKOUT_EN adds post-release lockout.
module walk_button_conditioner #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LOCKOUT_TICKS  = 200,
    parameter int CNT_W          = 8
) (
    input  logic WS_Clk,
    input  logic WS_Reset_n,
    input  logic WS_Button,
    input  logic WS_Tick,
    input  logic WS_Mask,
    output logic WS_Sync,
    output logic WS_Level
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] PRESSED      = 3'd2;
    localparam logic [2:0] RELEASE_WAIT = 3'd3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef WS_LOCKOUT_EN
    localparam logic [2:0] LOCKOUT = 3'd4;
    localparam logic [2:0] REL_NEXT = LOCKOUT;
    localparam logic [CNT_W-1:0] LK_LAST = CNT_W'(LOCKOUT_TICKS - 1);
`else
    localparam logic [2:0] REL_NEXT = IDLE;
`endif

    if (DEBOUNCE_TICKS < 1 || LOCKOUT_TICKS < 1 || CNT_W < 1) begin : g_bad_params
        $error("walk_button_conditioner: tick counts and CNT_W must be >= 1");
    end

    logic s1, s2, sync_n;
    logic [2:0] state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // A bounce always takes priority over a tick in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sync_n = 1'b0;
        case (state)
            IDLE:
                if (s2) begin
                    state_n = PRESS_WAIT;
                    cnt_n = '0;
                end
            PRESS_WAIT:
                if (!s2) state_n = IDLE;
                else if (WS_Tick && cnt == DB_LAST) begin
                    state_n = PRESSED;
                    sync_n = !WS_Mask;
                end else if (WS_Tick) cnt_n = cnt + 1'b1;
            PRESSED:
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                    cnt_n = '0;
                end
            RELEASE_WAIT:
                if (s2) state_n = PRESSED;
                else if (WS_Tick && cnt == DB_LAST) begin
                    state_n = REL_NEXT;
                    cnt_n = '0;
                end else if (WS_Tick) cnt_n = cnt + 1'b1;
`ifdef WS_LOCKOUT_EN
            LOCKOUT:
                if (WS_Tick) begin
                    state_n = cnt == LK_LAST ? IDLE : LOCKOUT;
                    cnt_n = cnt == LK_LAST ? '0 : cnt + 1'b1;
                end
`endif
            default: begin
                state_n = IDLE;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge WS_Clk) begin
        if (!WS_Reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            WS_Sync <= 1'b0;
            WS_Level <= 1'b0;
        end else begin
            s1 <= WS_Button;
            s2 <= s1;
            state <= state_n;
            cnt <= cnt_n;
            WS_Sync <= sync_n;
            WS_Level <= state_n == PRESSED || state_n == RELEASE_WAIT;
        end
    end
endmodule

// File: tb/tb_walk_button_conditioner.sv
// tb_walk_button_conditioner: directed stimulus checked against a stable-run debounce model plus literal latencies.
module tb_walk_button_conditioner;
    localparam int D = 4;
    localparam int L = 5;
`ifdef WS_LOCKOUT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, button, tick, mask;
    logic sync, level;
    int checks = 0, errors = 0, cyc = 0, npulse = 0, last_pulse = 0, div = 1, tcnt = 0;
    int p0, c0;

    always #5 clk = ~clk;

    walk_button_conditioner #(.DEBOUNCE_TICKS(D), .LOCKOUT_TICKS(L), .CNT_W(8)) dut (
        .WS_Clk(clk),
        .WS_Reset_n(rst_n),
        .WS_Button(button),
        .WS_Tick(tick),
        .WS_Mask(mask),
        .WS_Sync(sync),
        .WS_Level(level)
    );

    // Model: the debounced level flips once the two-flop-delayed button has
    // disagreed with it for D ticks, counted from the cycle after it first differs.
    logic m_s1 = 1'b0, m_s2 = 1'b0, lvl = 1'b0, waiting = 1'b0, exp_sync = 1'b0;
    int run = 0, lock = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
            lvl <= 1'b0;
            waiting <= 1'b0;
            exp_sync <= 1'b0;
            run <= 0;
            lock <= 0;
        end else begin
            m_s1 <= button;
            m_s2 <= m_s1;
            exp_sync <= 1'b0;
            if (lock != 0) begin
                if (tick) lock <= lock - 1;
            end else if (m_s2 == lvl) waiting <= 1'b0;
            else if (!waiting) begin
                waiting <= 1'b1;
                run <= 0;
            end else if (tick) begin
                if (run + 1 == D) begin
                    lvl <= !lvl;
                    waiting <= 1'b0;
                    exp_sync <= !lvl && !mask;
                    if (lvl && LK) lock <= L;
                end else run <= run + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sync) begin
            npulse++;
            last_pulse = cyc;
        end
        chk("sync_vs_model", int'(sync), int'(exp_sync));
        chk("level_vs_model", int'(level), int'(lvl));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            tick = (tcnt % div) == div - 1;
            tcnt++;
        end
    endtask

    task automatic wait_level(input logic v, input string name);
        for (int i = 0; i < 30 && level !== v; i++) step(1);
        chk(name, int'(level), int'(v));
    endtask

    initial begin
        rst_n = 1'b0;
        button = 1'b1;
        mask = 1'b0;
        tick = 1'b1;
        repeat (3) begin
            step(1);
            chk("reset_sync", int'(sync), 0);
            chk("reset_level", int'(level), 0);
        end
        rst_n = 1'b1;
        c0 = cyc;
        p0 = npulse;
        for (int i = 0; i < 20 && npulse == p0; i++) step(1);
        chk("reset_pulse_count", npulse - p0, 1);
        chk("reset_latency", last_pulse - c0, 7);
        chk("press_level", int'(level), 1);
        step(10);
        c0 = cyc;
        button = 1'b0;
        step(6);
        chk("release_level_hold", int'(level), 1);
        step(1);
        chk("release_level_drop", int'(level), 0);
        step(10);

        p0 = npulse;
        c0 = cyc;
        button = 1'b1;
        step(50);
        chk("clean_count", npulse - p0, 1);
        chk("clean_latency", last_pulse - c0, 7);
        chk("clean_level", int'(level), 1);
        button = 1'b0;
        step(10);
        chk("clean_released", int'(level), 0);

        p0 = npulse;
        for (int i = 0; i < 10; i++) begin
            button = ~button;
            step(2);
        end
        chk("bounce_count", npulse - p0, 0);
        chk("bounce_level", int'(level), 0);
        button = 1'b1;
        step(20);
        chk("bounce_then_hold", npulse - p0, 1);
        button = 1'b0;
        step(12);

        p0 = npulse;
        button = 1'b1;
        step(4);
        mask = 1'b1;
        step(4);
        mask = 1'b0;
        step(10);
        chk("mask_count", npulse - p0, 0);
        chk("mask_level", int'(level), 1);
        button = 1'b0;
        step(12);
        p0 = npulse;
        button = 1'b1;
        step(20);
        chk("unmask_count", npulse - p0, 1);
        button = 1'b0;
        step(12);

        div = 10;
        tcnt = 0;
        tick = 1'b0;
        p0 = npulse;
        c0 = cyc;
        button = 1'b1;
        step(39);
        chk("slow_level_before", int'(level), 0);
        chk("slow_count_before", npulse - p0, 0);
        step(2);
        chk("slow_count", npulse - p0, 1);
        chk("slow_latency", last_pulse - c0, 41);
        button = 1'b0;
        step(70);
        chk("slow_released", int'(level), 0);
        div = 1;
        step(2);

        button = 1'b1;
        step(20);
        button = 1'b0;
        wait_level(1'b0, "repress_release");
        c0 = cyc;
        p0 = npulse;
        button = 1'b1;
        step(9);
        chk("repress_early", npulse - p0, LK ? 0 : 1);
        step(1);
        chk("repress_count", npulse - p0, 1);
        chk("repress_latency", last_pulse - c0, LK ? 10 : 7);
        button = 1'b0;
        step(20);

        p0 = npulse;
        button = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(2);
        chk("midrst_sync", int'(sync), 0);
        chk("midrst_level", int'(level), 0);
        rst_n = 1'b1;
        c0 = cyc;
        step(8);
        chk("midrst_count", npulse - p0, 1);
        chk("midrst_latency", last_pulse - c0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
